// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipelined fetch sequencer.
//   seq_state_e : sequencer FSM states (RUN fetches, HALT idles until resume)
//   slot_t      : one pipeline slot at the default 8-bit opcode/PC widths
//   HALT_OP_DEF : default opcode that halts the sequencer when it retires
package pipe_seq_pkg;

  localparam int unsigned SLOT_OP_W_DEF = 8;
  localparam int unsigned SLOT_PC_W_DEF = 8;

  localparam logic [SLOT_OP_W_DEF-1:0] HALT_OP_DEF = 8'hFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic                     valid;
    logic [SLOT_OP_W_DEF-1:0] op;
    logic [SLOT_PC_W_DEF-1:0] npc;
  } slot_t;

  // Build a valid slot from a fetched opcode and its fetch PC.
  function automatic slot_t mk_slot(input logic [SLOT_OP_W_DEF-1:0] op,
                                    input logic [SLOT_PC_W_DEF-1:0] pc);
    slot_t s;
    s.valid = 1'b1;
    s.op    = op;
    s.npc   = pc + SLOT_PC_W_DEF'(1);
    return s;
  endfunction

endpackage

// File: rtl/pipe_seq_ctrl_if.sv
// Bus between the sequencer, instruction memory and the per-stage decoders.
//   master : sequencer side (drives pc/slot/status outputs, reads fetch data and controls)
//   slave  : environment side (memory + decoders + branch unit)
// Signals: instr_i, stall_i, br_taken_i, br_target_i, resume_i (into sequencer);
//          pc_o, fetch_en_o, slot_valid_o, slot_op_o, slot_npc_o, flush_o,
//          halted_o, retired_o (out of sequencer).
interface pipe_seq_ctrl_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned OP_W   = 8,
  parameter int unsigned CNT_W  = 16
);

  logic [OP_W-1:0]         instr_i;
  logic                    stall_i;
  logic                    br_taken_i;
  logic [PC_W-1:0]         br_target_i;
  logic                    resume_i;

  logic [PC_W-1:0]         pc_o;
  logic                    fetch_en_o;
  logic [STAGES-1:0]       slot_valid_o;
  logic [STAGES*OP_W-1:0]  slot_op_o;
  logic [STAGES*PC_W-1:0]  slot_npc_o;
  logic                    flush_o;
  logic                    halted_o;
  logic [CNT_W-1:0]        retired_o;

  modport master (
    input  instr_i, stall_i, br_taken_i, br_target_i, resume_i,
    output pc_o, fetch_en_o, slot_valid_o, slot_op_o, slot_npc_o,
           flush_o, halted_o, retired_o
  );

  modport slave (
    output instr_i, stall_i, br_taken_i, br_target_i, resume_i,
    input  pc_o, fetch_en_o, slot_valid_o, slot_op_o, slot_npc_o,
           flush_o, halted_o, retired_o
  );

endinterface

// File: rtl/pipe_slot_reg.sv
// One pipeline slot register {valid, op, npc}.
// Ports: clk, rst_n (sync active-low), load_i (capture valid_i/op_i/npc_i),
//        inv_i (clear valid, keep op/npc; wins over load_i),
//        valid_i/op_i/npc_i (next slot contents), valid_o/op_o/npc_o (slot state).
module pipe_slot_reg #(
  parameter int unsigned OP_W = 8,
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            inv_i,
  input  logic            valid_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [PC_W-1:0] npc_i,
  output logic            valid_o,
  output logic [OP_W-1:0] op_o,
  output logic [PC_W-1:0] npc_o
);

  logic            valid_q;
  logic [OP_W-1:0] op_q;
  logic [PC_W-1:0] npc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      npc_q   <= '0;
    end else if (inv_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      op_q    <= op_i;
      npc_q   <= npc_i;
    end
  end

  assign valid_o = valid_q;
  assign op_o    = op_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/pipe_seq_ctrl.sv
// Parametrised fetch/pipeline sequencer. Owns the fetch PC, moves
// {opcode, NPC, valid} through STAGES slots (slot 0 = fetch,
// slot STAGES-1 = execute/retire), handles stall, redirect/flush,
// halt/resume and counts retired instructions (saturating).
// Ports: clk, rst_n (sync active-low), bus (pipe_seq_ctrl_if.master;
//        see the interface file for the individual signals).
module pipe_seq_ctrl
  import pipe_seq_pkg::*;
#(
  parameter int unsigned     STAGES   = 3,
  parameter int unsigned     PC_W     = 8,
  parameter int unsigned     OP_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [OP_W-1:0] HALT_OP  = HALT_OP_DEF,
  parameter int unsigned     CNT_W    = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_seq_ctrl_if.master   bus
);

  localparam int unsigned XS = STAGES - 1;

  seq_state_e        state_q;
  logic [PC_W-1:0]   pc_q;
  logic              flush_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [STAGES-1:0] slot_v;
  logic [OP_W-1:0]   slot_op  [STAGES];
  logic [PC_W-1:0]   slot_npc [STAGES];

  logic              run;
  logic              redirect;
  logic              retire;
  logic              halt_hit;
  logic              kill;
  logic [PC_W-1:0]   pc_inc;

  assign run    = (state_q == RUN);
  assign pc_inc = pc_q + PC_W'(1);

  // A redirect is only honoured when the execute slot holds a real
  // instruction; it overrides stall and also retires that instruction.
  assign redirect = run & bus.br_taken_i & slot_v[XS];
  assign retire   = run & slot_v[XS] & (~bus.stall_i | redirect);
  // Halt only fires on an actual retire, and a same-cycle redirect wins.
  assign halt_hit = retire & ~redirect & (slot_op[XS] == HALT_OP);
  assign kill     = redirect | halt_hit;

  // Slot chain: slot 0 captures the fetch; slot k takes slot k-1.
  // In HALT every slot keeps shifting while slot 0 injects bubbles.
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    logic            ld;
    logic            inv;
    logic            v_in;
    logic [OP_W-1:0] op_in;
    logic [PC_W-1:0] npc_in;

    if (k == 0) begin : g_head
      assign ld     = run & ~bus.stall_i;
      assign inv    = kill | ~run;
      assign v_in   = 1'b1;
      assign op_in  = bus.instr_i;
      assign npc_in = pc_inc;
    end else begin : g_tail
      assign ld     = ~run | ~bus.stall_i;
      assign inv    = kill;
      assign v_in   = slot_v[k-1];
      assign op_in  = slot_op[k-1];
      assign npc_in = slot_npc[k-1];
    end

    pipe_slot_reg #(
      .OP_W (OP_W),
      .PC_W (PC_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (ld),
      .inv_i   (inv),
      .valid_i (v_in),
      .op_i    (op_in),
      .npc_i   (npc_in),
      .valid_o (slot_v[k]),
      .op_o    (slot_op[k]),
      .npc_o   (slot_npc[k])
    );
  end

  // PC, FSM, flush pulse and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      flush_q <= redirect;
      if (retire && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      case (state_q)
        RUN: begin
          if (redirect) begin
            pc_q <= bus.br_target_i;
          end else if (halt_hit) begin
            pc_q    <= slot_npc[XS];
            state_q <= HALT;
          end else if (!bus.stall_i) begin
            pc_q <= pc_inc;
          end
        end
        HALT: begin
          if (bus.resume_i) begin
            state_q <= RUN;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Pack per-slot fields onto the bus, slot k at [k*W +: W].
  logic [STAGES*OP_W-1:0] op_pack;
  logic [STAGES*PC_W-1:0] npc_pack;

  always_comb begin
    op_pack  = '0;
    npc_pack = '0;
    for (int k = 0; k < STAGES; k++) begin
      op_pack[k*OP_W +: OP_W]  = slot_op[k];
      npc_pack[k*PC_W +: PC_W] = slot_npc[k];
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.fetch_en_o   = run & ~bus.stall_i & ~redirect;
  assign bus.slot_valid_o = slot_v;
  assign bus.slot_op_o    = op_pack;
  assign bus.slot_npc_o   = npc_pack;
  assign bus.flush_o      = flush_q;
  assign bus.halted_o     = (state_q == HALT);
  assign bus.retired_o    = cnt_q;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
module tb_pipe_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  logic halt_en;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  pipe_seq_ctrl_if #(.STAGES(3), .PC_W(8), .OP_W(8), .CNT_W(16)) if1 ();
  pipe_seq_ctrl_if #(.STAGES(3), .PC_W(8), .OP_W(8), .CNT_W(4))  if2 ();

  pipe_seq_ctrl #(.STAGES(3), .PC_W(8), .OP_W(8), .RESET_PC(8'h00),
                  .HALT_OP(8'hFF), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  pipe_seq_ctrl #(.STAGES(3), .PC_W(8), .OP_W(8), .RESET_PC(8'h00),
                  .HALT_OP(8'hFF), .CNT_W(4)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (if2)
  );

  // Instruction memory: opcode = 8'h10 + address, optional HALT at address 7.
  assign if1.instr_i = (halt_en && if1.pc_o == 8'h07) ? 8'hFF : 8'(8'h10 + if1.pc_o);
  assign if2.instr_i = 8'(8'h10 + if2.pc_o);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    halt_en = 1'b0;
    if1.stall_i = 1'b0; if1.br_taken_i = 1'b0; if1.br_target_i = 8'h00; if1.resume_i = 1'b0;
    if2.stall_i = 1'b0; if2.br_taken_i = 1'b0; if2.br_target_i = 8'h00; if2.resume_i = 1'b0;
    step(); step();

    // Reset state
    chk("rst_pc",      64'(if1.pc_o),         64'h00);
    chk("rst_valid",   64'(if1.slot_valid_o), 64'h0);
    chk("rst_op",      64'(if1.slot_op_o),    64'h0);
    chk("rst_npc",     64'(if1.slot_npc_o),   64'h0);
    chk("rst_flush",   64'(if1.flush_o),      64'h0);
    chk("rst_halted",  64'(if1.halted_o),     64'h0);
    chk("rst_retired", 64'(if1.retired_o),    64'h0);

    // 1: five free-running cycles
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t1_pc",      64'(if1.pc_o),               64'h05);
    chk("t1_valid",   64'(if1.slot_valid_o),       64'h7);
    chk("t1_op",      64'(if1.slot_op_o),          64'h121314);
    chk("t1_npc2",    64'(if1.slot_npc_o[23:16]),  64'h03);
    chk("t1_retired", 64'(if1.retired_o),          64'h2);
    chk("t1_fetch",   64'(if1.fetch_en_o),         64'h1);

    // 2: stall three cycles, then continue
    if1.stall_i = 1'b1;
    #1;
    chk("t2_fetch_stall", 64'(if1.fetch_en_o), 64'h0);
    for (int i = 0; i < 3; i++) step();
    chk("t2_pc",      64'(if1.pc_o),         64'h05);
    chk("t2_op",      64'(if1.slot_op_o),    64'h121314);
    chk("t2_valid",   64'(if1.slot_valid_o), 64'h7);
    chk("t2_retired", 64'(if1.retired_o),    64'h2);
    chk("t2_flush",   64'(if1.flush_o),      64'h0);
    if1.stall_i = 1'b0;
    step();
    chk("t2_op_a",    64'(if1.slot_op_o),    64'h131415);
    chk("t2_ret_a",   64'(if1.retired_o),    64'h3);
    step();
    chk("t2_op_b",    64'(if1.slot_op_o),    64'h141516);
    chk("t2_pc_b",    64'(if1.pc_o),         64'h07);
    chk("t2_ret_b",   64'(if1.retired_o),    64'h4);

    // 3: branch at execute with stall in the same cycle
    if1.br_taken_i = 1'b1; if1.br_target_i = 8'h40; if1.stall_i = 1'b1;
    #1;
    chk("t3_fetch_redir", 64'(if1.fetch_en_o), 64'h0);
    step();
    if1.br_taken_i = 1'b0; if1.stall_i = 1'b0;
    chk("t3_pc",      64'(if1.pc_o),         64'h40);
    chk("t3_valid",   64'(if1.slot_valid_o), 64'h0);
    chk("t3_flush",   64'(if1.flush_o),      64'h1);
    chk("t3_retired", 64'(if1.retired_o),    64'h5);
    step();
    chk("t3_flush_end", 64'(if1.flush_o),      64'h0);
    chk("t3_pc_b",      64'(if1.pc_o),         64'h41);
    chk("t3_valid_b",   64'(if1.slot_valid_o), 64'h1);
    // branch on an invalid execute slot is ignored
    if1.br_taken_i = 1'b1; if1.br_target_i = 8'h99;
    step();
    if1.br_taken_i = 1'b0;
    chk("t3_ign_pc",    64'(if1.pc_o),         64'h42);
    chk("t3_ign_flush", 64'(if1.flush_o),      64'h0);
    chk("t3_ign_valid", 64'(if1.slot_valid_o), 64'h3);
    step();
    chk("t3_tgt_exec",  64'(if1.slot_op_o[23:16]), 64'h50);
    chk("t3_valid_c",   64'(if1.slot_valid_o),     64'h7);

    // 4: HALT_OP at pc 7
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; halt_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t4_not_yet", 64'(if1.halted_o), 64'h0);
    step();
    chk("t4_halted",  64'(if1.halted_o),     64'h1);
    chk("t4_pc",      64'(if1.pc_o),         64'h08);
    chk("t4_fetch",   64'(if1.fetch_en_o),   64'h0);
    chk("t4_valid",   64'(if1.slot_valid_o), 64'h0);
    chk("t4_retired", 64'(if1.retired_o),    64'h8);
    if1.br_taken_i = 1'b1; if1.br_target_i = 8'h33; if1.stall_i = 1'b1;
    step(); step();
    if1.br_taken_i = 1'b0; if1.stall_i = 1'b0;
    chk("t4_hold_pc",  64'(if1.pc_o),     64'h08);
    chk("t4_hold_hlt", 64'(if1.halted_o), 64'h1);
    if1.resume_i = 1'b1;
    step();
    if1.resume_i = 1'b0; halt_en = 1'b0;
    chk("t4_resumed", 64'(if1.halted_o),   64'h0);
    chk("t4_res_pc",  64'(if1.pc_o),       64'h08);
    chk("t4_res_fe",  64'(if1.fetch_en_o), 64'h1);
    step();
    chk("t4_pc_b",    64'(if1.pc_o),            64'h09);
    chk("t4_op0",     64'(if1.slot_op_o[7:0]),  64'h18);
    chk("t4_valid_b", 64'(if1.slot_valid_o),    64'h1);
    // resume in RUN has no effect
    if1.resume_i = 1'b1;
    step();
    if1.resume_i = 1'b0;
    step();
    chk("t4_run_res", 64'(if1.pc_o), 64'h0B);

    // 5: branch to 8'hFF, PC wraps
    if1.br_taken_i = 1'b1; if1.br_target_i = 8'hFF;
    step();
    if1.br_taken_i = 1'b0;
    chk("t5_pc_ff", 64'(if1.pc_o), 64'hFF);
    step();
    chk("t5_wrap",  64'(if1.pc_o),             64'h00);
    chk("t5_npc0",  64'(if1.slot_npc_o[7:0]),  64'h00);
    chk("t5_op0",   64'(if1.slot_op_o[7:0]),   64'h0F);
    step(); step();
    chk("t5_npc2",  64'(if1.slot_npc_o[23:16]), 64'h00);
    chk("t5_op2",   64'(if1.slot_op_o[23:16]),  64'h0F);

    // 6a: reset mid-stream with a redirect pending
    if1.br_taken_i = 1'b1; if1.br_target_i = 8'h77;
    rst_n = 1'b0;
    step();
    if1.br_taken_i = 1'b0;
    chk("t6_pc",      64'(if1.pc_o),         64'h00);
    chk("t6_valid",   64'(if1.slot_valid_o), 64'h0);
    chk("t6_op",      64'(if1.slot_op_o),    64'h0);
    chk("t6_npc",     64'(if1.slot_npc_o),   64'h0);
    chk("t6_flush",   64'(if1.flush_o),      64'h0);
    chk("t6_halted",  64'(if1.halted_o),     64'h0);
    chk("t6_retired", 64'(if1.retired_o),    64'h0);
    rst_n = 1'b1;

    // 6b: 4-bit counter saturates
    rst2_n = 1'b1;
    for (int i = 0; i < 17; i++) step();
    chk("t6_cnt14", 64'(if2.retired_o), 64'hE);
    for (int i = 0; i < 6; i++) step();
    chk("t6_sat",   64'(if2.retired_o), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
